// File: rtl/truth_table_checker_pkg.sv
// Shared types, default widths and the expected-table lookup for the response checker.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned IN_W_DEF  = 4;
  localparam int unsigned OUT_W_DEF = 3;

  // Lookup operates on a fixed-capacity table so one function serves every IN_W/OUT_W.
  localparam int unsigned TBL_MAX_W = 1024;
  localparam int unsigned OUT_MAX_W = 8;
  localparam int unsigned IDX_W     = $clog2(TBL_MAX_W);
  localparam int unsigned OSEL_W    = $clog2(OUT_MAX_W);

  // Returns entry idx of a packed table whose entries are w bits wide.
  function automatic logic [OUT_MAX_W-1:0] exp_lookup(
    input logic [TBL_MAX_W-1:0] tbl,
    input int unsigned          idx,
    input int unsigned          w = OUT_W_DEF
  );
    logic [OUT_MAX_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < OUT_MAX_W; b++) begin
      if (b < w) begin
        r[OSEL_W'(b)] = tbl[IDX_W'(idx * w + b)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Vector/response stream into the checker, with valid/ready handshake.
interface truth_table_checker_if
  import truth_table_checker_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
);

  logic             vec_valid;
  logic             vec_ready;
  logic [IN_W-1:0]  vec_in;
  logic [OUT_W-1:0] resp_in;

  modport master (
    output vec_valid,
    output vec_in,
    output resp_in,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_in,
    input  resp_in,
    output vec_ready
  );

endinterface

// File: rtl/truth_table_checker_compare_stage.sv
// Stage register for one accepted pair plus its table lookup and mismatch flag.
module tt_compare_stage
  import truth_table_checker_pkg::*;
#(
  parameter int unsigned                     IN_W      = IN_W_DEF,
  parameter int unsigned                     OUT_W     = OUT_W_DEF,
  parameter logic [(2**IN_W)*OUT_W-1:0]      EXP_TABLE = 48'hFAC688FAC688
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [IN_W-1:0]  vec_in,
  input  logic [OUT_W-1:0] resp_in,
  output logic             stage_valid,
  output logic [IN_W-1:0]  stage_vec,
  output logic [OUT_W-1:0] stage_got,
  output logic [OUT_W-1:0] stage_exp,
  output logic             mismatch
);

  logic [OUT_W-1:0] exp_c;

  assign exp_c = OUT_W'(exp_lookup(TBL_MAX_W'(EXP_TABLE), 32'(vec_in), OUT_W));

  // Capture the pair and its compare result; the stage empties on clear or when nothing is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_vec   <= '0;
      stage_got   <= '0;
      stage_exp   <= '0;
      mismatch    <= 1'b0;
    end else if (clear) begin
      stage_valid <= 1'b0;
      stage_vec   <= '0;
      stage_got   <= '0;
      stage_exp   <= '0;
      mismatch    <= 1'b0;
    end else begin
      stage_valid <= load;
      if (load) begin
        stage_vec <= vec_in;
        stage_got <= resp_in;
        stage_exp <= exp_c;
        mismatch  <= (exp_c != resp_in);
      end
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Checks (vector, response) pairs against an expected truth table and keeps coverage/error statistics.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int unsigned                IN_W      = IN_W_DEF,
  parameter int unsigned                OUT_W     = OUT_W_DEF,
  parameter logic [(2**IN_W)*OUT_W-1:0] EXP_TABLE = 48'hFAC688FAC688
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  truth_table_checker_if.slave  bus,
  output logic [(2**IN_W)-1:0]  covered,
  output logic [IN_W:0]         err_count,
  output logic [IN_W-1:0]       first_fail_vec,
  output logic [OUT_W-1:0]      first_fail_got,
  output logic [OUT_W-1:0]      first_fail_exp,
  output logic                  done,
  output logic                  pass
);

  localparam int unsigned DEPTH = 2**IN_W;
  localparam int unsigned CNT_W = IN_W + 1;

  state_t state_q, state_d;

  logic             stage_valid;
  logic [IN_W-1:0]  stage_vec;
  logic [OUT_W-1:0] stage_got;
  logic [OUT_W-1:0] stage_exp;
  logic             mismatch;
  logic [DEPTH-1:0] stage_onehot;
  logic [DEPTH-1:0] covered_d;
  logic             cov_full_d;
  logic             accept;

  // Coverage as it will stand once the staged pair retires.
  assign stage_onehot = DEPTH'(1) << stage_vec;
  assign covered_d    = covered | stage_onehot;
  assign cov_full_d   = &covered_d;

  // Stop accepting while the stage holds the vector that completes coverage.
  assign bus.vec_ready = (state_q == RUN) && !(stage_valid && cov_full_d);
  assign accept        = bus.vec_valid && bus.vec_ready && !start;

  tt_compare_stage #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .EXP_TABLE (EXP_TABLE)
  ) u_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start),
    .load        (accept),
    .vec_in      (bus.vec_in),
    .resp_in     (bus.resp_in),
    .stage_valid (stage_valid),
    .stage_vec   (stage_vec),
    .stage_got   (stage_got),
    .stage_exp   (stage_exp),
    .mismatch    (mismatch)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start always (re)enters RUN; RUN ends when the staged pair completes coverage.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (start)                          state_d = RUN;
        else if (stage_valid && cov_full_d) state_d = DONE;
      end
      DONE: begin
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Retire the staged compare into coverage, error count, first-failure capture and verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      covered        <= '0;
      err_count      <= '0;
      first_fail_vec <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (start) begin
      covered        <= '0;
      err_count      <= '0;
      first_fail_vec <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (stage_valid) begin
      covered <= covered_d;
      if (mismatch) begin
        if (err_count != '1) begin
          err_count <= err_count + CNT_W'(1);
        end
        if (err_count == '0) begin
          first_fail_vec <= stage_vec;
          first_fail_got <= stage_got;
          first_fail_exp <= stage_exp;
        end
      end
      if (cov_full_d) begin
        done <= 1'b1;
        pass <= (err_count == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: the driver predicts each accepted pair's effect, a monitor compares it two cycles later.
module tb_truth_table_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] covered;
  logic [4:0]  err_count;
  logic [3:0]  first_fail_vec;
  logic [2:0]  first_fail_got;
  logic [2:0]  first_fail_exp;
  logic        done;
  logic        pass;

  truth_table_checker_if #(.IN_W(4), .OUT_W(3)) bus ();

  truth_table_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .bus            (bus),
    .covered        (covered),
    .err_count      (err_count),
    .first_fail_vec (first_fail_vec),
    .first_fail_got (first_fail_got),
    .first_fail_exp (first_fail_exp),
    .done           (done),
    .pass           (pass)
  );

  typedef struct {
    int          due;
    logic [15:0] cov;
    int          err;
    int          fv;
    int          fg;
    int          fe;
    bit          dn;
    bit          ps;
  } snap_t;

  snap_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  // Reference model state.
  bit seen[16];
  int m_err, m_fv, m_fg, m_fe;
  bit m_run;
  int ready_until;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic [15:0] model_cov();
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) if (seen[i]) c[i] = 1'b1;
    return c;
  endfunction

  function automatic bit model_done();
    return model_cov() == 16'hFFFF;
  endfunction

  function automatic bit exp_ready();
    return m_run && (cyc <= ready_until);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    m_err = 0; m_fv = 0; m_fg = 0; m_fe = 0;
    ready_until = 32'h7fffffff;
  endtask

  // Apply one accepted pair to the model; the effect becomes visible two edges later.
  task automatic model_accept(input int v, input int r);
    snap_t s;
    int    expv;
    bit    was_done;
    was_done = model_done();
    expv = v % 8;
    if (r != expv) begin
      if (m_err == 0) begin
        m_fv = v; m_fg = r; m_fe = expv;
      end
      m_err = (m_err < 31) ? m_err + 1 : 31;
    end
    seen[v] = 1'b1;
    if (!was_done && model_done()) ready_until = cyc;
    s.due = cyc + 2;
    s.cov = model_cov();
    s.err = m_err;
    s.fv  = m_fv;
    s.fg  = m_fg;
    s.fe  = m_fe;
    s.dn  = model_done();
    s.ps  = model_done() && (m_err == 0);
    q.push_back(s);
  endtask

  // Monitor: compare DUT statistics against the predicted snapshot when it falls due.
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        s = q.pop_front();
        if (s.due < cyc) begin
          chk("snapshot_due", cyc, s.due);
        end else begin
          chk("covered", covered, s.cov);
          chk("err_count", err_count, s.err);
          chk("first_fail_vec", first_fail_vec, s.fv);
          chk("first_fail_got", first_fail_got, s.fg);
          chk("first_fail_exp", first_fail_exp, s.fe);
          chk("done", done, s.dn);
          chk("pass", pass, s.ps);
        end
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send(input int v, input int r);
    bit ok;
    ok = 1'b0;
    bus.vec_valid = 1'b1;
    bus.vec_in    = 4'(v);
    bus.resp_in   = 3'(r);
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      chk("vec_ready", bus.vec_ready, exp_ready());
      if (bus.vec_ready) begin
        model_accept(v, r);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bus.vec_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("vec_ready_idle", bus.vec_ready, exp_ready());
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    bus.vec_valid = 1'b0;
    for (int n = 0; n < 10 && q.size() > 0; n++) begin
      @(posedge clk); #1;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_start(input bit with_valid, input int v, input int r);
    start         = 1'b1;
    bus.vec_valid = with_valid;
    bus.vec_in    = 4'(v);
    bus.resp_in   = 3'(r);
    @(posedge clk); #1;
    start         = 1'b0;
    bus.vec_valid = 1'b0;
    model_clear();
    m_run = 1'b1;
    @(negedge clk);
    chk("start_covered", covered, 0);
    chk("start_err", err_count, 0);
    chk("start_done", done, 0);
    chk("start_ready", bus.vec_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_covered"}, covered, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_ffvec"}, first_fail_vec, 0);
    chk({tag, "_ffgot"}, first_fail_got, 0);
    chk({tag, "_ffexp"}, first_fail_exp, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_ready"}, bus.vec_ready, 0);
  endtask

  initial begin
    int gap, r, v, n;
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.vec_valid = 1'b0;
    bus.vec_in    = '0;
    bus.resp_in   = '0;
    m_run         = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean sweep 0..15; done/pass appear two cycles after the last accept.
    do_start(1'b0, 0, 0);
    for (int i = 0; i < 16; i++) send(i, i % 8);
    bus.vec_valid = 1'b0;
    @(negedge clk);
    chk("last_in_stage_ready", bus.vec_ready, 0);
    chk("last_in_stage_done", done, 0);
    @(posedge clk); #1;
    wait_drain();
    chk("clean_pass", pass, 1);

    // Restart from DONE with a concurrent pair, then single-fault sweep (vector 5 answered 0).
    do_start(1'b1, 2, 7);
    for (int i = 0; i < 16; i++) send(i, (i == 5) ? 0 : i % 8);
    wait_drain();
    chk("single_ffvec", first_fail_vec, 5);
    chk("single_pass", pass, 0);

    // Two faults: first one is kept.
    do_start(1'b0, 0, 0);
    for (int i = 0; i < 16; i++) send(i, (i == 3 || i == 9) ? (i % 8) ^ 1 : i % 8);
    wait_drain();
    chk("multi_err", err_count, 2);
    chk("multi_ffvec", first_fail_vec, 3);

    // Reverse sweep with random gaps and random faulty responses.
    do_start(1'b0, 0, 0);
    for (int i = 15; i >= 0; i--) begin
      gap = $urandom_range(0, 2);
      idle(gap);
      r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : i % 8;
      send(i, r);
    end
    wait_drain();

    // Duplicates of vector 0 with a wrong answer: count saturates, coverage stays one bit.
    do_start(1'b0, 0, 0);
    for (int i = 0; i < 40; i++) send(0, 7);
    wait_drain();
    chk("sat_err", err_count, 31);
    chk("sat_done", done, 0);

    // start in RUN while a pair is offered and ready is high: the pair is discarded.
    do_start(1'b1, 4, 0);
    idle(2);
    chk("discard_covered", covered, 0);
    chk("discard_err", err_count, 0);

    // Random-order sweep until every vector is seen.
    do_start(1'b0, 0, 0);
    n = 0;
    while (!model_done() && n < 300) begin
      v = $urandom_range(0, 15);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : v % 8;
      send(v, r);
      n++;
    end
    wait_drain();
    chk("random_done", done, model_done());

    // Reset after 7 accepts: everything clears at once and vec_valid is ignored until start.
    do_start(1'b0, 0, 0);
    for (int i = 0; i < 7; i++) send($urandom_range(0, 15), $urandom_range(0, 7));
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    model_clear();
    m_run = 1'b0;
    check_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_ready", bus.vec_ready, 0);
      chk("idle_covered", covered, 0);
    end
    @(posedge clk); #1;
    do_start(1'b0, 0, 0);
    for (int i = 0; i < 16; i++) send(i, i % 8);
    wait_drain();
    chk("after_reset_pass", pass, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Hardware response checker for the 4-input/3-output combinational logic blocks in this project.
- Consumes a stream of (input vector, DUT response) pairs and compares each response against a parameterised expected truth table.
- Tracks which of the 2^IN_W vectors have been seen, counts mismatches and records the first failure.
- Sits at the receiving end of a stimulus sweep: a sweep generator or board switches drive vec_in, the DUT outputs drive resp_in.

Parameters:
- IN_W, 4: input vector width; table depth is 2^IN_W.
- OUT_W, 3: response width.
- EXP_TABLE, 48'hFAC688FAC688: packed expected table; entry i occupies bits [OUT_W*i+OUT_W-1 : OUT_W*i]. The default gives entry i = i[2:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; clears all statistics and enters RUN.
- vec_valid  in  1  vec_in/resp_in pair is valid.
- vec_ready  out  1  checker accepts the pair this cycle.
- vec_in  in  IN_W  applied input vector (A is MSB, D is LSB).
- resp_in  in  OUT_W  DUT response (X is MSB, Z is LSB).
- covered  out  2^IN_W  bit i set once vector i has been checked.
- err_count  out  IN_W+1  mismatch count, saturating.
- first_fail_vec  out  IN_W  vector of the first mismatch.
- first_fail_got  out  OUT_W  response received at the first mismatch.
- first_fail_exp  out  OUT_W  expected response at the first mismatch.
- done  out  1  all vectors covered.
- pass  out  1  done and err_count == 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; stage register empty; every output 0, including vec_ready, covered, err_count, first_fail_*, done and pass.
- States:
  - IDLE: start goes to RUN.
  - RUN: the stage register completing coverage goes to DONE; start restarts RUN.
  - DONE: start goes to RUN. Otherwise the state holds.
- start effect: start in any state clears covered, err_count, first_fail_* and the stage register on the same edge. start wins over a concurrent accept, which is discarded.
- Handshake:
  - vec_ready = (state==RUN) and not (stage valid and its vector is the last uncovered one); this term is combinational from the stage register and covered.
  - A transfer occurs when vec_valid && vec_ready; one pair per cycle maximum.
  - vec_valid outside RUN is ignored.
- Pipeline: a pair accepted in cycle N is held in the stage register during N+1. Its compare result updates covered, err_count and first_fail_* at the end of N+1, visible in N+2. Back-to-back accepts sustain 1 pair/cycle.
- Compare: expected = EXP_TABLE slice at index vec_in. A mismatch is any bit difference.
- err_count: increments on each mismatch and saturates at 2^(IN_W+1)-1 (31); it never wraps.
- first_fail_*: loaded only when err_count==0 before the update; held thereafter until start or reset.
- Duplicate vectors: compared and counted again; the covered bit is unchanged. Vector order is arbitrary.
- done: asserts on the same edge that sets the final covered bit (covered all-ones and done visible in the same cycle). pass = done && (err_count==0). Both hold until start or reset.
- Reset mid-operation: immediate return to the reset values; no partial state survives.

Decomposition:
- Shared package (project_pkg):
  - state enum {IDLE, RUN, DONE};
  - IN_W and OUT_W defaults;
  - function exp_lookup(table, idx).
- One sub-module is natural: tt_compare_stage, which holds the stage register, does the table lookup and produces the mismatch flag. The top level owns the FSM, covered, counters and the first-fail capture.

Test Plan:
- Full clean sweep:
  - Stimulus: reset, start, then vectors 0..15 back-to-back with resp = i[2:0].
  - Response: vec_ready stays high until the cycle vector 15 sits in stage; done=1 and pass=1 two cycles after the vector 15 accept; err_count=0; covered=16'hFFFF.
- Single fault:
  - Stimulus: sweep with vector 5 answered 3'b000.
  - Response: err_count=1; first_fail_vec=5, first_fail_got=0, first_fail_exp=5; done=1, pass=0.
- Multiple faults:
  - Stimulus: vectors 3 and 9 wrong.
  - Response: err_count=2; first_fail_vec=3 (first kept); plus reverse-order sweep 15..0 with gaps in vec_valid giving done only after all 16 are seen.
- Duplicates and saturation:
  - Stimulus: vector 0 sent 40 times with resp=3'b111.
  - Response: err_count=31 (saturated); covered=16'h0001; done=0.
- Reset mid-run:
  - Stimulus: rst_n low after 7 accepts.
  - Response: all outputs 0 immediately, state IDLE, vec_ready=0 until start.
- Restart:
  - Stimulus: start in DONE with a concurrent vec_valid.
  - Response: statistics cleared, the concurrent pair discarded, RUN entered, a fresh sweep passes.
